// File: rtl/sprite_pkg.sv
// Shared types for the sprite mover: per-axis direction and the per-frame
// update sequencer state.
package sprite_pkg;

    typedef enum logic {
        DIR_POS,
        DIR_NEG
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC_X,
        CALC_Y
    } mover_state_t;

    // Reverse an axis direction after it hits a screen edge.
    function automatic dir_t flip_dir(input dir_t d);
        return (d == DIR_POS) ? DIR_NEG : DIR_POS;
    endfunction

endpackage

// File: rtl/sprite_mover.sv
// Sprite mover: once per frame steps the sprite position and bounces it off
// the screen edges through one shared add/compare path (X first, then Y), and
// on every line requests a sprite line draw when the beam is inside the
// sprite's vertical extent.
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int CORDW  = 10,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int SPR_W  = 8,
    parameter int SPR_H  = 8,
    parameter int SPEED  = 1,
    parameter int X_INIT = 0,
    parameter int Y_INIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame,
    input  logic             line,
    input  logic [CORDW-1:0] sy,
    input  logic             en,
    output logic [CORDW-1:0] sprx,
    output logic [CORDW-1:0] spry,
    output logic             dir_x,
    output logic             dir_y,
    output logic             bounce_x,
    output logic             bounce_y,
    output logic             start
);

    // Arithmetic carries one extra bit so pos+SPEED and pos-SPEED never wrap.
    localparam logic [CORDW:0]   SPD    = (CORDW+1)'(SPEED);
    localparam logic [CORDW-1:0] SPD_N  = CORDW'(SPEED);
    localparam logic [CORDW:0]   HGT    = (CORDW+1)'(SPR_H);
    localparam logic [CORDW-1:0] LIM_X  = CORDW'(H_RES - SPR_W);
    localparam logic [CORDW-1:0] LIM_Y  = CORDW'(V_RES - SPR_H);
    localparam logic [CORDW-1:0] XI     = CORDW'(X_INIT);
    localparam logic [CORDW-1:0] YI     = CORDW'(Y_INIT);

    mover_state_t     r_state;
    mover_state_t     w_next;
    logic             w_do_x;
    logic             w_do_y;

    logic [CORDW-1:0] r_sprx;
    logic [CORDW-1:0] r_spry;
    dir_t             r_dir_x;
    dir_t             r_dir_y;
    logic             r_bounce_x;
    logic             r_bounce_y;
    logic             r_start;

    logic [CORDW-1:0] w_cur;
    dir_t             w_dir;
    logic [CORDW-1:0] w_lim;
    logic [CORDW:0]   w_pos;
    logic [CORDW:0]   w_sum;
    logic [CORDW-1:0] w_dif;
    logic [CORDW-1:0] w_new;
    logic             w_flip;
    logic [CORDW:0]   w_sy;
    logic [CORDW:0]   w_top;
    logic [CORDW:0]   w_bot;
    logic             w_hit;

    // Sequencer state register; reset abandons any update in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: a frame with motion enabled kicks off the X then Y steps.
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = (frame && en) ? CALC_X : IDLE;
            CALC_X:  w_next = CALC_Y;
            CALC_Y:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Sequencer outputs: which axis owns the shared arithmetic this cycle.
    always_comb begin
        w_do_x = (r_state == CALC_X);
        w_do_y = (r_state == CALC_Y);
    end

    // Shared add/compare path, muxed onto the axis being updated.
    always_comb begin
        w_cur  = w_do_y ? r_spry  : r_sprx;
        w_dir  = w_do_y ? r_dir_y : r_dir_x;
        w_lim  = w_do_y ? LIM_Y   : LIM_X;
        w_pos  = {1'b0, w_cur};
        w_sum  = w_pos + SPD;
        w_dif  = w_cur - SPD_N;
        w_new  = w_cur;
        w_flip = 1'b0;
        if (w_dir == DIR_POS) begin
            if (w_sum >= {1'b0, w_lim}) begin
                w_new  = w_lim;
                w_flip = 1'b1;
            end else begin
                w_new  = w_sum[CORDW-1:0];
            end
        end else begin
            if (w_pos <= SPD) begin
                w_new  = '0;
                w_flip = 1'b1;
            end else begin
                w_new  = w_dif;
            end
        end
    end

    // Horizontal position, direction and bounce pulse, written in CALC_X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sprx     <= XI;
            r_dir_x    <= DIR_POS;
            r_bounce_x <= 1'b0;
        end else begin
            r_bounce_x <= w_do_x & w_flip;
            if (w_do_x) begin
                r_sprx <= w_new;
                if (w_flip) begin
                    r_dir_x <= flip_dir(r_dir_x);
                end
            end
        end
    end

    // Vertical position, direction and bounce pulse, written in CALC_Y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_spry     <= YI;
            r_dir_y    <= DIR_POS;
            r_bounce_y <= 1'b0;
        end else begin
            r_bounce_y <= w_do_y & w_flip;
            if (w_do_y) begin
                r_spry <= w_new;
                if (w_flip) begin
                    r_dir_y <= flip_dir(r_dir_y);
                end
            end
        end
    end

    // Line window test against the registered spry, so a coincident frame
    // update never affects the current line's decision.
    always_comb begin
        w_sy  = {1'b0, sy};
        w_top = {1'b0, r_spry};
        w_bot = w_top + HGT;
        w_hit = line && (w_sy >= w_top) && (w_sy < w_bot);
    end

    // Registered one-cycle draw request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start <= 1'b0;
        end else begin
            r_start <= w_hit;
        end
    end

    assign sprx     = r_sprx;
    assign spry     = r_spry;
    assign dir_x    = (r_dir_x == DIR_NEG);
    assign dir_y    = (r_dir_y == DIR_NEG);
    assign bounce_x = r_bounce_x;
    assign bounce_y = r_bounce_y;
    assign start    = r_start;

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: random frame/line/enable traffic compared every
// cycle against a behavioural model, plus directed edge cases.
module tb_sprite_mover;

    localparam int CORDW  = 10;
    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int SPR_W  = 32;
    localparam int SPR_H  = 32;
    localparam int SPEED  = 4;
    localparam int X_INIT = 100;
    localparam int Y_INIT = 50;
    localparam int LIM_X  = H_RES - SPR_W;
    localparam int LIM_Y  = V_RES - SPR_H;

    logic             clk = 1'b0;
    logic             rst;
    logic             frame;
    logic             line;
    logic [CORDW-1:0] sy;
    logic             en;
    logic [CORDW-1:0] sprx;
    logic [CORDW-1:0] spry;
    logic             dir_x;
    logic             dir_y;
    logic             bounce_x;
    logic             bounce_y;
    logic             start;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_x, m_y;
    bit m_dx, m_dy, m_bx, m_by, m_start;
    int m_wait;   // cycles until pending X update (2) / Y update (1); 0 = none

    sprite_mover #(
        .CORDW(CORDW), .H_RES(H_RES), .V_RES(V_RES), .SPR_W(SPR_W), .SPR_H(SPR_H),
        .SPEED(SPEED), .X_INIT(X_INIT), .Y_INIT(Y_INIT)
    ) dut (
        .clk(clk), .rst(rst), .frame(frame), .line(line), .sy(sy), .en(en),
        .sprx(sprx), .spry(spry), .dir_x(dir_x), .dir_y(dir_y),
        .bounce_x(bounce_x), .bounce_y(bounce_y), .start(start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = X_INIT; m_y = Y_INIT;
        m_dx = 0; m_dy = 0; m_bx = 0; m_by = 0; m_start = 0;
        m_wait = 0;
    endtask

    // One axis step: move by SPEED, clamp at an edge and reverse.
    task automatic axis_step(inout int p, inout bit d, output bit b, input int lim);
        b = 0;
        if (!d) begin
            if (p + SPEED >= lim) begin p = lim; d = 1; b = 1; end
            else p = p + SPEED;
        end else begin
            if (p <= SPEED) begin p = 0; d = 0; b = 1; end
            else p = p - SPEED;
        end
    endtask

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_step();
        int ys;
        ys = int'(sy);
        m_start = line && (ys >= m_y) && (ys < m_y + SPR_H);
        m_bx = 0; m_by = 0;
        if (m_wait == 2) begin
            axis_step(m_x, m_dx, m_bx, LIM_X);
            m_wait = 1;
        end else if (m_wait == 1) begin
            axis_step(m_y, m_dy, m_by, LIM_Y);
            m_wait = 0;
        end else if (frame && en) begin
            m_wait = 2;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sprx"},     32'(sprx),     32'(m_x));
        chk({tag, ".spry"},     32'(spry),     32'(m_y));
        chk({tag, ".dir_x"},    32'(dir_x),    32'(m_dx));
        chk({tag, ".dir_y"},    32'(dir_y),    32'(m_dy));
        chk({tag, ".bounce_x"}, 32'(bounce_x), 32'(m_bx));
        chk({tag, ".bounce_y"}, 32'(bounce_y), 32'(m_by));
        chk({tag, ".start"},    32'(start),    32'(m_start));
    endtask

    // Apply inputs already set, clock once, update the model, check at negedge.
    task automatic cyc(input string tag);
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic set_in(input logic f, input logic l, input int s, input logic e);
        frame = f; line = l; sy = CORDW'(s); en = e;
    endtask

    initial begin
        int s;
        int saw_bx, saw_by, ymark;

        // Power-up reset, checked before any clock edge
        rst = 1'b1;
        set_in(0, 0, 0, 1);
        model_reset();
        #2;
        check_all("por");
        @(negedge clk);
        rst = 1'b0;
        cyc("idle0");

        // Random traffic: enough frames to bounce off all four edges
        saw_bx = 0; saw_by = 0;
        for (int i = 0; i < 4000; i++) begin
            s = m_y - 2 + int'($urandom_range(0, SPR_H + 3));
            if (s < 0) s = 0;
            set_in(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, s,
                   ($urandom_range(0, 7) != 0));
            cyc("rand");
            if (bounce_x) saw_bx++;
            if (bounce_y) saw_by++;
        end
        chk("rand.bounce_x_seen", 32'(saw_bx > 1), 32'd1);
        chk("rand.bounce_y_seen", 32'(saw_by > 1), 32'd1);

        // Let any update in flight finish
        set_in(0, 0, 0, 1);
        repeat (4) cyc("drain");

        // Enable low: ten frames, nothing moves, no bounce pulses
        begin
            int x0, y0;
            x0 = m_x; y0 = m_y;
            for (int i = 0; i < 10; i++) begin
                set_in(1, 0, 0, 0);
                cyc("en0");
                set_in(0, 0, 0, 0);
                repeat (3) cyc("en0");
            end
            chk("en0.sprx_hold", 32'(sprx), 32'(x0));
            chk("en0.spry_hold", 32'(spry), 32'(y0));
        end

        // Start window boundaries around the current spry
        ymark = m_y;
        if (ymark > 0) begin
            set_in(0, 1, ymark - 1, 1); cyc("win.above");
            chk("win.above_start", 32'(start), 32'd0);
        end
        set_in(0, 1, ymark, 1);             cyc("win.top");
        chk("win.top_start", 32'(start), 32'd1);
        set_in(0, 0, ymark, 1);             cyc("win.top_next");
        chk("win.top_single", 32'(start), 32'd0);
        set_in(0, 1, ymark + SPR_H - 1, 1); cyc("win.bot");
        chk("win.bot_start", 32'(start), 32'd1);
        set_in(0, 1, ymark + SPR_H, 1);     cyc("win.below");
        chk("win.below_start", 32'(start), 32'd0);

        // Coincident frame + line at the top row: old spry decides start
        set_in(1, 1, ymark, 1);
        cyc("coin.n1");
        chk("coin.start", 32'(start), 32'd1);
        set_in(0, 0, 0, 1);
        cyc("coin.n2");
        cyc("coin.n3");
        chk("coin.spry_moved", 32'(spry != CORDW'(ymark)), 32'd1);
        repeat (2) cyc("coin.tail");

        // Reset during CALC_Y with a start pulse pending
        set_in(1, 1, m_y, 1);
        cyc("rst.f");
        set_in(0, 0, 0, 1);
        cyc("rst.calcy");
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rst.async");
        cyc("rst.hold");
        rst = 1'b0;
        // FSM back in IDLE: a new frame updates X two cycles later
        set_in(1, 0, 0, 1);
        cyc("rst.f2");
        set_in(0, 0, 0, 1);
        cyc("rst.x");
        chk("rst.sprx_step", 32'(sprx), 32'(X_INIT + SPEED));
        repeat (3) cyc("rst.tail");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_mover.md
# sprite_mover

Upstream controller for a 1-bit hardware sprite drawing engine. Once per frame, during blanking, it updates the sprite's on-screen position and bounces it off the screen edges. On every line it issues the `start` pulse that tells the downstream sprite engine to draw one sprite line. It sits between the display timing generator (which supplies `frame`, `line` and `sy`) and the sprite engine (which consumes `start` and `sprx`).

## Interface
- `CORDW`, 10: screen coordinate width in bits.
- `H_RES`, 640: active horizontal resolution.
- `V_RES`, 480: active vertical resolution.
- `SPR_W`, 8: drawn sprite width in pixels, after scaling.
- `SPR_H`, 8: drawn sprite height in lines, after scaling.
- `SPEED`, 1: pixels moved per axis per frame. Requires 1 ≤ SPEED < H_RES−SPR_W and SPEED < V_RES−SPR_H.
- `X_INIT`, 0 / `Y_INIT`, 0: position after reset.

Ports:
- `clk` input 1: clock. Single clock domain.
- `rst` input 1: reset, asynchronous and active-high.
- `frame` input 1: one-cycle pulse once per frame, at the start of vertical blanking.
- `line` input 1: one-cycle pulse at the start of each line (sx==0).
- `sy` input CORDW: current vertical screen position.
- `en` input 1: motion enable, sampled on `frame`.
- `sprx` output CORDW: sprite horizontal position (left edge).
- `spry` output CORDW: sprite vertical position (top edge).
- `dir_x` output 1: horizontal direction, 0 = increasing x, 1 = decreasing x.
- `dir_y` output 1: vertical direction, 0 = increasing y, 1 = decreasing y.
- `bounce_x` / `bounce_y` output 1: one-cycle pulse when the axis reverses.
- `start` output 1: one-cycle pulse requesting one sprite line.

## Operation
- FSM states: IDLE, CALC_X, CALC_Y.
  - IDLE → CALC_X when `frame && en`; otherwise stays in IDLE.
  - CALC_X → CALC_Y unconditionally.
  - CALC_Y → IDLE unconditionally.
  - `frame` while in CALC_X or CALC_Y is ignored.
- One shared add/compare path, used by X in CALC_X and by Y in CALC_Y. Limits are LIM_X = H_RES−SPR_W and LIM_Y = V_RES−SPR_H.
- Arithmetic is done in CORDW+1 bits, so pos+SPEED and pos−SPEED never wrap.
- Positive direction:
  - If pos+SPEED ≥ LIM: pos ← LIM, direction flips, bounce pulses.
  - Otherwise: pos ← pos+SPEED.
- Negative direction:
  - If pos ≤ SPEED: pos ← 0, direction flips, bounce pulses.
  - Otherwise: pos ← pos−SPEED.
- `start` fires when `line` is high and sy ≥ spry and sy < spry+SPR_H, using the registered `spry`.
- If `frame` and `line` coincide, the `start` decision uses the pre-update `spry`.
- `en` low: position and direction hold, no bounce pulses; `start` still operates.

## Timing
- Reset values, applied immediately and asynchronously:
  - `sprx` = X_INIT, `spry` = Y_INIT
  - `dir_x` = `dir_y` = 0
  - `bounce_x` = `bounce_y` = `start` = 0
  - FSM in IDLE
- `rst` asserted mid-update (in CALC_X or CALC_Y) abandons the update and loads the reset values.
- `frame` high at cycle N:
  - CALC_X at N+1.
  - `sprx`, `dir_x`, `bounce_x` update at N+2.
  - `spry`, `dir_y`, `bounce_y` update at N+3.
  - Back in IDLE at N+3.
- `start` is registered: `line` at cycle N gives `start` high at N+1 only.
- All outputs are registered. No combinational input-to-output paths.

## Structure
- Shared package `sprite_pkg`:
  - `dir_t` enum {DIR_POS, DIR_NEG}
  - `mover_state_t` enum {IDLE, CALC_X, CALC_Y}
- No sub-module. The single shared arithmetic path is muxed by the FSM, so per-axis instances would duplicate logic.

## Test plan
Parameters for all scenarios: H_RES=640, V_RES=480, SPR_W=SPR_H=32, SPEED=4.
- Reset: pulse `rst` while in CALC_Y with X_INIT=100, Y_INIT=50 → `sprx`=100, `spry`=50, `dir_x`=`dir_y`=0, FSM in IDLE, all pulses 0, asserted without waiting for a clock edge.
- Right bounce: X_INIT=600, `en`=1, three `frame` pulses →
  - `sprx` goes 604, then 608.
  - `bounce_x` pulses at N+2 of the second frame; `dir_x`=1.
  - Third frame gives `sprx`=604.
- Left/top clamp: `sprx`=2 with `dir_x`=1; `spry`=3 with `dir_y`=1; one `frame` →
  - `sprx`=0, `dir_x`=0, `bounce_x` pulse.
  - `spry`=0, `dir_y`=0, `bounce_y` pulse one cycle later.
- Enable low: `en`=0, ten `frame` pulses → `sprx`/`spry`/`dir_*` unchanged, no bounce pulses.
- Start window: `spry`=100 →
  - `line` with `sy`=99 gives no `start`.
  - `sy`=100 and `sy`=131 each give a one-cycle `start` one cycle after `line`.
  - `sy`=132 gives no `start`.
- Coincident `frame` + `line` with `sy`=100, `spry`=100, moving to 104 → `start` pulses (old `spry` used); `spry`=104 at N+3.
